// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the sort-RAM arbiter: controller state encoding and
// the default RAM geometry used by the arbiter, its interface and the RAM.
package ram_arbiter_pkg;

    localparam int RAM_ADDR_W = 3;
    localparam int RAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Ownership state that belongs to a given port number.
    function automatic arb_state_e own_state(input logic port);
        return port ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the sort-RAM arbiter: both request/address/write
// channels, both grants and the shared read-data broadcast.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);

    logic              req0;
    logic [ADDR_W-1:0] add0;
    logic              wr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;

    logic              req1;
    logic [ADDR_W-1:0] add1;
    logic              wr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;

    logic [DATA_W-1:0] rdata;

    // Requesters: host load/readback engine (port 0) and sort controller (port 1).
    modport master (
        output req0, add0, wr0, wdata0,
        output req1, add1, wr1, wdata1,
        input  gnt0, gnt1, rdata
    );

    // Arbiter side.
    modport slave (
        input  req0, add0, wr0, wdata0,
        input  req1, add1, wr1, wdata1,
        output gnt0, gnt1, rdata
    );

endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single-port 8x8 sort RAM. Grants are
// registered (decoded from state), contention is resolved round-robin and a
// burst counter hands the RAM over once the owner has held it MAX_BURST
// cycles while the other port waits. The address/write/data mux is inline.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = RAM_ADDR_W,
    parameter int DATA_W    = RAM_DATA_W,
    parameter int MAX_BURST = 16,   // 0 = unlimited burst
    parameter int CNT_W     = 5     // 2**CNT_W must exceed MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,  // asynchronous, active low
    ram_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] ram_add,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam bit             LIMITED    = (MAX_BURST != 0);
    localparam logic [CNT_W-1:0] BURST_LAST = LIMITED ? CNT_W'(MAX_BURST - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;   // port that most recently won the RAM

    logic [1:0] req;
    logic       owner;                  // port number of the current owner
    logic       other;
    logic       limit_hit;

    assign req   = {bus.req1, bus.req0};
    assign owner = (state_q == OWN1);
    assign other = ~owner;

    // The counter keeps climbing (saturating) while the owner is alone, so the
    // limit test is ">=": a port that shows up late after a long solo burst is
    // served at the next edge instead of waiting for a value that never recurs.
    assign limit_hit = LIMITED && (cnt_q >= BURST_LAST);

    // State, burst counter and last-winner registers; reset drops the grant at once.
    // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic: round-robin on ties, bounded bursts, direct handover.
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req[0] && (!req[1] || last_q)) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (req[1]) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (req[owner] && !(limit_hit && req[other])) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end else if (req[other]) begin
                    state_d = own_state(other);
                    cnt_d   = '0;
                    last_d  = other;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // RAM-side mux: the owner's address/write/data, all zero while idle.
    always_comb begin
        ram_add   = '0;
        ram_wr    = 1'b0;
        ram_wdata = '0;
        case (state_q)
            OWN0: begin
                ram_add   = bus.add0;
                ram_wr    = bus.wr0;
                ram_wdata = bus.wdata0;
            end
            OWN1: begin
                ram_add   = bus.add1;
                ram_wr    = bus.wr1;
                ram_wdata = bus.wdata1;
            end
            default: ;
        endcase
    end

    assign bus.gnt0  = (state_q == OWN0);
    assign bus.gnt1  = (state_q == OWN1);
    assign bus.rdata = ram_rdata;
    assign busy      = bus.gnt0 | bus.gnt1;

endmodule
